// File: rtl/common_pkg.sv
// Shared constants for the core: architectural PC reset value and fetch granularity.
package common;

    localparam logic [63:0] PC_INIT     = 64'h8000_0000;
    localparam logic [63:0] INSTR_BYTES = 64'd4;

endpackage

// File: rtl/pipes_pkg.sv
// Pipeline-stage types shared between fetch and its consumers.
package pipes;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_out_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC select for fetch: redirect beats sequential advance, otherwise hold.
module pc_next
    import common::*;
(
    input  logic [63:0] pc,
    input  logic        advance,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] next_pc
);

    always_comb begin
        next_pc = pc;
        if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (advance) begin
            next_pc = pc + INSTR_BYTES;
        end
    end

endmodule

// File: rtl/fetch.sv
// Single-outstanding instruction fetch with a one-entry decode buffer and flush handling.
module fetch
    import common::*;
    import pipes::*;
#(
    parameter logic [63:0] RESET_PC = PC_INIT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready
);

    fetch_state_t state_q;
    fetch_out_t   out_q;
    logic [63:0]  pc_q;
    logic [63:0]  pc_d;
    logic         advance;

    // PC only steps when a live response is accepted into the buffer.
    assign advance = (state_q == S_REQ) && iresp_data_ok && !redirect_valid;

    pc_next u_pc_next (
        .pc             (pc_q),
        .advance        (advance),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .next_pc        (pc_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            out_q   <= '0;
        end else begin
            pc_q <= pc_d;
            unique case (state_q)
                S_REQ: begin
                    if (redirect_valid) begin
                        // A response arriving with the redirect closes the old request.
                        state_q <= iresp_data_ok ? S_REQ : S_DROP;
                    end else if (iresp_data_ok) begin
                        out_q.valid <= 1'b1;
                        out_q.pc    <= pc_q;
                        out_q.instr <= iresp_data;
                        state_q     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid || out_ready) begin
                        out_q.valid <= 1'b0;
                        state_q     <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (iresp_data_ok) begin
                        state_q <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_REQ;
                end
            endcase
            if (redirect_valid) begin
                out_q.valid <= 1'b0;
            end
        end
    end

    assign ireq_valid = (state_q != S_HOLD);
    assign ireq_addr  = {pc_q[63:2], 2'b00};
    assign out_valid  = out_q.valid;
    assign out_pc     = out_q.pc;
    assign out_instr  = out_q.instr;

endmodule

// File: tb/tb_fetch.sv
// Directed vector bench for fetch: table of per-cycle stimulus/expectations plus reset sequences.
module tb_fetch;

    localparam logic [63:0] A = 64'h8000_0000;

    typedef struct {
        logic        ok;
        logic [31:0] data;
        logic        rv;
        logic [63:0] rpc;
        logic        rdy;
        logic        e_iv;
        logic [63:0] e_addr;
        logic        e_ov;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        logic        chk_buf;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok = 1'b0;
    logic [31:0] iresp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;

    int n_checks = 0;
    int n_err = 0;
    vec_t vecs[$];

    fetch dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ok, input logic [31:0] data, input logic rv,
                                input logic [63:0] rpc, input logic rdy, input logic e_iv,
                                input logic [63:0] e_addr, input logic e_ov,
                                input logic [63:0] e_pc, input logic [31:0] e_instr,
                                input logic chk_buf);
        vec_t v;
        v.ok = ok; v.data = data; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.e_iv = e_iv; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc = e_pc;
        v.e_instr = e_instr; v.chk_buf = chk_buf;
        return v;
    endfunction

    task automatic drive(input logic ok, input logic [31:0] data, input logic rv,
                         input logic [63:0] rpc, input logic rdy);
        iresp_data_ok  = ok;
        iresp_data     = data;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
    endtask

    initial begin
        // ok, data, rv, rpc, rdy | iv, addr, ov, pc, instr, chk_buf
        // First fetch: data returns on the third cycle.
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, A, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, A, 0, 0, 0, 1));
        vecs.push_back(mk(1, 32'h13, 0, 0, 0, 0, A + 4, 1, A, 32'h13, 1));
        // Back-pressure for five cycles.
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, A + 4, 1, A, 32'h13, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, A + 4, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h93, 0, 0, 0, 0, A + 8, 1, A + 4, 32'h93, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, A + 8, 0, 0, 0, 0));
        // Redirect with request outstanding, stale response three cycles later.
        vecs.push_back(mk(0, 0, 1, A + 64'h100, 0, 1, A + 64'h100, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, A + 64'h100, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, A + 64'h100, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'hdead_beef, 0, 0, 0, 1, A + 64'h100, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h113, 0, 0, 0, 0, A + 64'h104, 1, A + 64'h100, 32'h113, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, A + 64'h104, 0, 0, 0, 0));
        // Redirect coincident with data_ok.
        vecs.push_back(mk(1, 32'hbad0_0bad, 1, A + 64'h200, 0, 1, A + 64'h200, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h213, 0, 0, 0, 0, A + 64'h204, 1, A + 64'h200, 32'h213, 1));
        // Redirect in S_HOLD together with out_ready.
        vecs.push_back(mk(0, 0, 1, A + 64'h300, 1, 1, A + 64'h300, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h313, 0, 0, 0, 0, A + 64'h304, 1, A + 64'h300, 32'h313, 1));
        // Two redirects while dropping: the later one wins.
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, A + 64'h304, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, A + 64'h400, 0, 1, A + 64'h400, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, A + 64'h500, 0, 1, A + 64'h500, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h1111, 0, 0, 0, 1, A + 64'h500, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h513, 0, 0, 0, 0, A + 64'h504, 1, A + 64'h500, 32'h513, 1));
        // Redirect in S_HOLD without out_ready, then PC wraps at 2^64.
        vecs.push_back(mk(0, 0, 1, 64'hffff_ffff_ffff_fffc, 0, 1, 64'hffff_ffff_ffff_fffc, 0, 0, 0,
                          0));
        vecs.push_back(mk(1, 32'hfff, 0, 0, 0, 0, 64'h0, 1, 64'hffff_ffff_ffff_fffc, 32'hfff, 1));
        // Unaligned redirect: address is masked, buffered PC is the raw PC.
        vecs.push_back(mk(0, 0, 1, A + 64'h603, 0, 1, A + 64'h600, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h613, 0, 0, 0, 0, A + 64'h604, 1, A + 64'h603, 32'h613, 1));

        // Reset state, checked before any clock edge.
        #2;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_instr", {32'd0, out_instr}, 64'd0);
        #10 reset = 1'b1;
        #1;
        check("first_ireq_valid", {63'd0, ireq_valid}, 64'd1);
        check("first_ireq_addr", ireq_addr, A);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].ok, vecs[i].data, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ireq_valid", i), {63'd0, ireq_valid}, {63'd0, vecs[i].e_iv});
            check($sformatf("v%0d_ireq_addr", i), ireq_addr, vecs[i].e_addr);
            check($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].e_ov});
            if (vecs[i].chk_buf) begin
                check($sformatf("v%0d_out_pc", i), out_pc, vecs[i].e_pc);
                check($sformatf("v%0d_out_instr", i), {32'd0, out_instr}, {32'd0, vecs[i].e_instr});
            end
        end

        // Async reset with the buffer full: outputs clear before any clock edge.
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        check("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_out_pc", out_pc, 64'd0);
        check("async_rst_out_instr", {32'd0, out_instr}, 64'd0);
        check("async_rst_ireq_valid", {63'd0, ireq_valid}, 64'd1);
        check("async_rst_ireq_addr", ireq_addr, A);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ireq_addr", ireq_addr, A);

        // Async reset mid-request, response pending; request restarts at RESET_PC.
        @(negedge clk);
        drive(0, 0, 1, A + 64'h700, 0);
        @(posedge clk);
        #1;
        check("pre_rst2_ireq_addr", ireq_addr, A + 64'h700);
        drive(0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        check("rst2_ireq_addr", ireq_addr, A);
        check("rst2_out_valid", {63'd0, out_valid}, 64'd0);
        #3 reset = 1'b1;
        @(negedge clk);
        drive(1, 32'h13, 0, 0, 0);
        @(posedge clk);
        #1;
        check("rst2_fetch_out_valid", {63'd0, out_valid}, 64'd1);
        check("rst2_fetch_out_pc", out_pc, A);
        check("rst2_fetch_out_instr", {32'd0, out_instr}, 64'h13);
        check("rst2_fetch_ireq_addr", ireq_addr, A + 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
